// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses at num/den of refclk.
// Enables are gated until PLL lock has held for SETTLE_CYCLES; cfg_load phase-aligns all channels.
module clk_enable_gen #(
  parameter int NUM_CH        = 4,
  parameter int ACC_W         = 16,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] cfg_num,
  input  logic [NUM_CH*ACC_W-1:0] cfg_den,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_pause,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready,
  output logic [NUM_CH-1:0]       cfg_err
);

  localparam int CNT_W  = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LAST_I = (SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] SETTLE_LAST = LAST_I[CNT_W-1:0];

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;

  logic [ACC_W-1:0] num_q [NUM_CH];
  logic [ACC_W-1:0] den_q [NUM_CH];
  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W:0]   sum   [NUM_CH];
  logic [ACC_W-1:0] diff  [NUM_CH];
  logic             step_en;

  // The edge that sees lock in WAIT_LOCK counts as the first settle cycle, so
  // ready rises exactly SETTLE_CYCLES locked edges after lock is first seen.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (pll_locked) begin
            settle_cnt <= '0;
            if (SETTLE_CYCLES <= 1) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (!pll_locked) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!pll_locked) begin
            state <= WAIT_LOCK;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign step_en = (state == RUN) && pll_locked;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]  = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
      diff[i] = sum[i][ACC_W-1:0] - den_q[i];
    end
  end

  // Load has priority over stepping; acc < den is kept, so sum never overflows ACC_W+1.
  always_ff @(posedge refclk) begin
    if (rst) begin
      ce      <= '0;
      cfg_err <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        num_q[i] <= '0;
        den_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else if (cfg_load) begin
      ce <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        num_q[i]   <= cfg_num[i*ACC_W +: ACC_W];
        den_q[i]   <= cfg_den[i*ACC_W +: ACC_W];
        acc_q[i]   <= '0;
        cfg_err[i] <= (cfg_den[i*ACC_W +: ACC_W] == '0) ||
                      (cfg_num[i*ACC_W +: ACC_W] > cfg_den[i*ACC_W +: ACC_W]);
      end
    end else if (!step_en) begin
      ce <= '0;
      if (state == RUN) begin
        for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_pause[i] || den_q[i] == '0) begin
          ce[i] <= 1'b0;
        end else if (num_q[i] > den_q[i]) begin
          ce[i]    <= 1'b1;
          acc_q[i] <= '0;
        end else if (sum[i] >= {1'b0, den_q[i]}) begin
          ce[i]    <= 1'b1;
          acc_q[i] <= diff[i];
        end else begin
          ce[i]    <= 1'b0;
          acc_q[i] <= sum[i][ACC_W-1:0];
        end
      end
    end
  end

endmodule
